// File: rtl/spi_slave_regs.sv
// SPI mode-0 responder with a 16 x 8-bit register file; SCK/SS_n/MOSI are oversampled on CLK_100MHz.
// Pins reach edge detection SYNC_STAGES+1 clocks late, so SCK phases must last at least 4 system clocks.
module spi_slave_regs #(
  parameter logic [7:0] DEVICE_ID   = 8'hA5,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        CLK_100MHz,
  input  logic        rst,
  input  logic        spi_sck_i,
  input  logic        spi_ss_n_i,
  input  logic        spi_mosi_i,
  output logic        spi_miso_o,
  output logic        spi_miso_t,
  input  logic [15:0] status_in,
  output logic [15:0] ctrl_out,
  output logic        wr_stb,
  output logic [3:0]  wr_addr,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sck_sync_q, ss_sync_q, mosi_sync_q, settle_q;
  logic       sck_prev_q;
  logic       ss_prev_q;
  logic       armed_q;
  logic [2:0] bit_cnt_q;
  logic [6:0] rx_q;
  logic [7:0] tx_q;
  logic [3:0] addr_q;
  logic       wr_q;
  logic       byte_done_q;
  logic       wr_stb_q;
  logic [3:0] wr_addr_q;
  logic [7:0] rw_q [3:15];

  logic       sck_s, ss_s, mosi_s, settled;
  logic       sck_rise, sck_fall, ss_fall;
  logic [7:0] rx_next;
  logic [7:0] rd_byte;

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign ss_s     = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign settled  = settle_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  // A reset taken mid-frame must not see the still-low SS_n as a new frame start.
  assign ss_fall  = ss_prev_q & ~ss_s & armed_q;
  assign rx_next  = {rx_q, mosi_s};

  always_comb begin
    rd_byte = 8'h00;
    case (addr_q)
      4'h0: rd_byte = DEVICE_ID;
      4'h1: rd_byte = status_in[7:0];
      4'h2: rd_byte = status_in[15:8];
      default: begin
        for (int i = 3; i < 16; i++) begin
          if (addr_q == i[3:0]) rd_byte = rw_q[i];
        end
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    if (ss_s) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (ss_fall) state_d = ST_CMD;
        ST_CMD:  if (sck_rise && bit_cnt_q == 3'd7) state_d = ST_DATA;
        ST_DATA: state_d = ST_DATA;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK_100MHz or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge CLK_100MHz or posedge rst) begin
    if (rst) begin
      sck_sync_q  <= '0;
      ss_sync_q   <= '1;
      mosi_sync_q <= '0;
      settle_q    <= '0;
      sck_prev_q  <= 1'b0;
      ss_prev_q   <= 1'b1;
      armed_q     <= 1'b0;
      bit_cnt_q   <= 3'd0;
      rx_q        <= 7'd0;
      tx_q        <= 8'd0;
      addr_q      <= 4'd0;
      wr_q        <= 1'b0;
      byte_done_q <= 1'b0;
      wr_stb_q    <= 1'b0;
      wr_addr_q   <= 4'd0;
      for (int i = 3; i < 16; i++) rw_q[i] <= 8'd0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck_i};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], spi_ss_n_i};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
      settle_q    <= {settle_q[SYNC_STAGES-2:0], 1'b1};
      sck_prev_q  <= sck_s;
      ss_prev_q   <= ss_s;
      if (settled && ss_s) armed_q <= 1'b1;
      wr_stb_q    <= 1'b0;

      if (state_q == ST_IDLE || ss_s) begin
        bit_cnt_q   <= 3'd0;
        byte_done_q <= 1'b0;
        tx_q        <= 8'd0;
      end else if (sck_rise) begin
        rx_q      <= rx_next[6:0];
        bit_cnt_q <= bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          byte_done_q <= 1'b1;
          if (state_q == ST_CMD) begin
            wr_q   <= rx_next[7];
            addr_q <= rx_next[3:0];
          end else if (wr_q) begin
            if (addr_q >= 4'd3) begin
              for (int i = 3; i < 16; i++) begin
                if (addr_q == i[3:0]) rw_q[i] <= rx_next;
              end
              wr_stb_q  <= 1'b1;
              wr_addr_q <= addr_q;
            end
            addr_q <= addr_q + 4'd1;
          end
        end
      end else if (sck_fall) begin
        if (byte_done_q) begin
          byte_done_q <= 1'b0;
          if (!wr_q) begin
            tx_q   <= rd_byte;
            addr_q <= addr_q + 4'd1;
          end else begin
            tx_q <= 8'd0;
          end
        end else begin
          tx_q <= {tx_q[6:0], 1'b0};
        end
      end
    end
  end

  assign spi_miso_o = tx_q[7];
  assign spi_miso_t = (state_q == ST_IDLE);
  assign ctrl_out   = {rw_q[4], rw_q[3]};
  assign wr_stb     = wr_stb_q;
  assign wr_addr    = wr_addr_q;
  assign busy       = ~ss_s;

endmodule

// File: tb/tb_spi_slave_regs.sv
// Directed bench for spi_slave_regs: SPI master model at 10 MHz SCK, checks read/write/wrap/abort/reset.
module tb_spi_slave_regs;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sck = 1'b0;
  logic        ss_n = 1'b1;
  logic        mosi = 1'b0;
  logic        miso, miso_t;
  logic [15:0] status_in = 16'h0000;
  logic [15:0] ctrl_out;
  logic        wr_stb;
  logic [3:0]  wr_addr;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int stb_cnt = 0;
  logic [3:0] addr_log [$];

  spi_slave_regs #(.DEVICE_ID(8'hA5), .SYNC_STAGES(2)) dut (
    .CLK_100MHz (clk),
    .rst        (rst),
    .spi_sck_i  (sck),
    .spi_ss_n_i (ss_n),
    .spi_mosi_i (mosi),
    .spi_miso_o (miso),
    .spi_miso_t (miso_t),
    .status_in  (status_in),
    .ctrl_out   (ctrl_out),
    .wr_stb     (wr_stb),
    .wr_addr    (wr_addr),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_stb) begin
      stb_cnt++;
      addr_log.push_back(wr_addr);
    end
  end

  localparam int HALF = 50;

  task automatic spi_start();
    ss_n = 1'b0;
    #100;
  endtask

  task automatic spi_end();
    #HALF;
    ss_n = 1'b1;
    #200;
  endtask

  task automatic spi_bits(input logic [7:0] v, input int n, output logic [7:0] r);
    r = 8'h00;
    for (int i = 0; i < n; i++) begin
      mosi = v[7-i];
      #HALF;
      r = {r[6:0], miso};
      sck = 1'b1;
      #HALF;
      sck = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] v, output logic [7:0] r);
    spi_bits(v, 8, r);
  endtask

  task automatic test_reset();
    #2;
    #50;
    total++; if (miso_t !== 1'b1)    begin bad++; $display("FAIL rst_miso_t got=%b want=1", miso_t); end
    total++; if (ctrl_out !== 16'h0) begin bad++; $display("FAIL rst_ctrl got=%h want=0000", ctrl_out); end
    total++; if (wr_stb !== 1'b0)    begin bad++; $display("FAIL rst_stb got=%b want=0", wr_stb); end
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    total++; if (wr_addr !== 4'h0)   begin bad++; $display("FAIL rst_wr_addr got=%h want=0", wr_addr); end
    total++; if (miso !== 1'b0)      begin bad++; $display("FAIL rst_miso got=%b want=0", miso); end
    rst = 1'b0;
    #100;
  endtask

  task automatic test_read_id();
    logic [7:0] r0, r1;
    spi_start();
    total++; if (busy !== 1'b1)   begin bad++; $display("FAIL id_busy got=%b want=1", busy); end
    total++; if (miso_t !== 1'b0) begin bad++; $display("FAIL id_miso_t got=%b want=0", miso_t); end
    spi_byte(8'h00, r0);
    spi_byte(8'h00, r1);
    spi_end();
    total++; if (r0 !== 8'h00) begin bad++; $display("FAIL id_cmd_byte got=%h want=00", r0); end
    total++; if (r1 !== 8'hA5) begin bad++; $display("FAIL id_value got=%h want=a5", r1); end
    total++; if (miso_t !== 1'b1) begin bad++; $display("FAIL id_idle_t got=%b want=1", miso_t); end
  endtask

  task automatic test_burst_write();
    logic [7:0] r;
    int base;
    base = stb_cnt;
    addr_log.delete();
    spi_start();
    spi_byte(8'h83, r);
    spi_byte(8'h34, r);
    spi_byte(8'h12, r);
    spi_end();
    total++; if (ctrl_out !== 16'h1234) begin bad++; $display("FAIL bw_ctrl got=%h want=1234", ctrl_out); end
    total++; if (stb_cnt - base !== 2)  begin bad++; $display("FAIL bw_stb_count got=%0d want=2", stb_cnt - base); end
    if (addr_log.size() == 2) begin
      total++; if (addr_log[0] !== 4'h3) begin bad++; $display("FAIL bw_addr0 got=%h want=3", addr_log[0]); end
      total++; if (addr_log[1] !== 4'h4) begin bad++; $display("FAIL bw_addr1 got=%h want=4", addr_log[1]); end
    end
    total++; if (wr_addr !== 4'h4) begin bad++; $display("FAIL bw_wr_addr got=%h want=4", wr_addr); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] r;
    int base;
    spi_start();
    spi_byte(8'h83, r);
    spi_bits(8'h56, 3, r);
    rst = 1'b1;
    #30;
    total++; if (miso_t !== 1'b1)    begin bad++; $display("FAIL mr_miso_t got=%b want=1", miso_t); end
    total++; if (ctrl_out !== 16'h0) begin bad++; $display("FAIL mr_ctrl got=%h want=0000", ctrl_out); end
    total++; if (wr_stb !== 1'b0)    begin bad++; $display("FAIL mr_stb got=%b want=0", wr_stb); end
    rst = 1'b0;
    base = stb_cnt;
    spi_bits(8'h00, 5, r);
    spi_byte(8'h99, r);
    total++; if (miso_t !== 1'b1)    begin bad++; $display("FAIL mr_ignored_t got=%b want=1", miso_t); end
    spi_end();
    total++; if (ctrl_out !== 16'h0) begin bad++; $display("FAIL mr_ignored_ctrl got=%h want=0000", ctrl_out); end
    total++; if (stb_cnt !== base)   begin bad++; $display("FAIL mr_ignored_stb got=%0d want=%0d", stb_cnt, base); end
  endtask

  task automatic test_wrap();
    logic [7:0] r, r0, r1;
    int base;
    base = stb_cnt;
    addr_log.delete();
    spi_start();
    spi_byte(8'h8F, r);
    spi_byte(8'h5A, r);
    spi_byte(8'hC3, r);
    spi_end();
    total++; if (stb_cnt - base !== 1) begin bad++; $display("FAIL wrap_stb_count got=%0d want=1", stb_cnt - base); end
    total++; if (wr_addr !== 4'hF)     begin bad++; $display("FAIL wrap_wr_addr got=%h want=f", wr_addr); end
    spi_start();
    spi_byte(8'h0F, r);
    spi_byte(8'h00, r0);
    spi_byte(8'h00, r1);
    spi_end();
    total++; if (r0 !== 8'h5A) begin bad++; $display("FAIL wrap_rd_f got=%h want=5a", r0); end
    total++; if (r1 !== 8'hA5) begin bad++; $display("FAIL wrap_rd_0 got=%h want=a5", r1); end
  endtask

  task automatic test_status();
    logic [7:0] r, r0, r1;
    status_in = 16'hBEEF;
    spi_start();
    spi_byte(8'h01, r);
    spi_byte(8'h00, r0);
    spi_byte(8'h00, r1);
    spi_end();
    total++; if (r0 !== 8'hEF) begin bad++; $display("FAIL status_lo got=%h want=ef", r0); end
    total++; if (r1 !== 8'hBE) begin bad++; $display("FAIL status_hi got=%h want=be", r1); end
  endtask

  task automatic test_abort();
    logic [7:0] r, r0;
    int base;
    spi_start();
    spi_byte(8'h85, r);
    spi_byte(8'h77, r);
    spi_end();
    base = stb_cnt;
    spi_start();
    spi_byte(8'h85, r);
    spi_bits(8'hFF, 5, r);
    spi_end();
    total++; if (stb_cnt !== base) begin bad++; $display("FAIL abort_stb got=%0d want=%0d", stb_cnt, base); end
    total++; if (miso_t !== 1'b1)  begin bad++; $display("FAIL abort_idle got=%b want=1", miso_t); end
    spi_start();
    spi_byte(8'h05, r);
    spi_byte(8'h00, r0);
    spi_end();
    total++; if (r0 !== 8'h77) begin bad++; $display("FAIL abort_reg5 got=%h want=77", r0); end
    total++; if (ctrl_out !== 16'h0000) begin bad++; $display("FAIL abort_ctrl got=%h want=0000", ctrl_out); end
  endtask

  initial begin
    test_reset();
    test_read_id();
    test_burst_write();
    test_reset_mid_frame();
    test_read_id();
    test_wrap();
    test_status();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
